adder_share_arbiter: RTL and testbench

- Shares one combinational WIDTH-bit adder (nsumador-class, ports a/b/result) between NREQ filter-channel requesters in the image-filter datapath.
- Round-robin arbitration, valid/ready handshake on each requester, registered operands to the shared adder, and a registered response tagged with the requester id.
- Sits between the per-channel filter stages and the single shared adder instance.

---
 rtl/adder_share_arbiter_if.sv | 33 +++
 rtl/adder_share_arbiter.sv | 96 +++++++++
 tb/tb_adder_share_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/adder_share_arbiter_if.sv
// rtl/adder_share_arbiter_if.sv - requester, shared-adder and response signals of adder_share_arbiter
interface adder_share_arbiter_if #(
    parameter int WIDTH = 5,
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int CNTW  = 16
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic [WIDTH-1:0]      add_a;
    logic [WIDTH-1:0]      add_b;
    logic [WIDTH-1:0]      add_result;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_ready;
    logic                  busy;
    logic [CNTW-1:0]       op_count;

    // Arbiter side.
    modport slave (
        input  req_valid, req_a, req_b, add_result, rsp_ready,
        output req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum, busy, op_count
    );

    // Requesters, shared adder and response consumer side.
    modport master (
        output req_valid, req_a, req_b, add_result, rsp_ready,
        input  req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum, busy, op_count
    );
endinterface

// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - round-robin arbiter sharing one combinational adder among NREQ requesters
module adder_share_arbiter #(
    parameter int WIDTH = 5,
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int CNTW  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    adder_share_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t           state_q;
    logic [IDW-1:0]   last_grant_q;
    logic [WIDTH-1:0] add_a_q;
    logic [WIDTH-1:0] add_b_q;
    logic [WIDTH-1:0] rsp_sum_q;
    logic [IDW-1:0]   rsp_id_q;
    logic             rsp_valid_q;
    logic             busy_q;
    logic [CNTW-1:0]  op_count_q;

    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   cand;

    // Scan starts just after the last winner, so a continuously valid set rotates.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last_grant_q) + k) % NREQ);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign bus.req_ready = (rst_n && state_q == IDLE && grant_found)
                         ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_idx) : '0;

    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.busy      = busy_q;
    assign bus.op_count  = op_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= IDW'(NREQ - 1);
            add_a_q      <= '0;
            add_b_q      <= '0;
            rsp_sum_q    <= '0;
            rsp_id_q     <= '0;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            op_count_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        add_a_q      <= bus.req_a[grant_idx*WIDTH +: WIDTH];
                        add_b_q      <= bus.req_b[grant_idx*WIDTH +: WIDTH];
                        rsp_id_q     <= grant_idx;
                        last_grant_q <= grant_idx;
                        busy_q       <= 1'b1;
                        state_q      <= CALC;
                    end
                end
                CALC: begin
                    rsp_sum_q   <= bus.add_result;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        op_count_q  <= op_count_q + CNTW'(1);
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb/tb_adder_share_arbiter.sv - randomized self-checking bench for adder_share_arbiter
module tb_adder_share_arbiter;
    localparam int WIDTH = 5;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int CNTW  = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    adder_share_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) ifc ();
    assign ifc.add_result = ifc.add_a + ifc.add_b;

    adder_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    int pass_cnt = 0;
    int total_cnt = 0;
    int model_last;
    int model_count;
    logic [WIDTH-1:0] opa [NREQ];
    logic [WIDTH-1:0] opb [NREQ];

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
        int order[$];
        for (int k = 1; k <= NREQ; k++) order.push_back((last + k) % NREQ);
        foreach (order[i]) if (v[order[i]]) return order[i];
        return -1;
    endfunction

    function automatic logic [WIDTH-1:0] ref_sum(input int g);
        return WIDTH'((int'(opa[g]) + int'(opb[g])) % (1 << WIDTH));
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int g);
        logic [NREQ-1:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_ops();
        for (int i = 0; i < NREQ; i++) begin
            ifc.req_a[i*WIDTH +: WIDTH] = opa[i];
            ifc.req_b[i*WIDTH +: WIDTH] = opb[i];
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ifc.req_valid = '0;
        ifc.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_last = NREQ - 1;
        model_count = 0;
    endtask

    // Presents v, waits (bounded) for a grant, then waits (bounded) for rsp_valid.
    task automatic issue(input logic [NREQ-1:0] v, input bit hold, output logic [NREQ-1:0] rdy,
                         output int waits, output int lat, output logic [IDW-1:0] id,
                         output logic [WIDTH-1:0] sum);
        set_ops();
        ifc.req_valid = v;
        #1;
        waits = 0;
        while (ifc.req_ready == '0 && waits < 20) begin tick(); waits++; end
        rdy = ifc.req_ready;
        lat = -1; id = '0; sum = '0;
        if (rdy == '0) return;
        tick();
        if (!hold) ifc.req_valid = ifc.req_valid & ~rdy;
        lat = 1;
        while (!ifc.rsp_valid && lat < 10) begin tick(); lat++; end
        id = ifc.rsp_id;
        sum = ifc.rsp_sum;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifc.req_valid = '1;
        ifc.rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin opa[i] = '0; opb[i] = '0; end
        set_ops();
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if (ifc.req_ready !== '0) $display("FAIL reset_req_ready: got %b expected 0", ifc.req_ready); else pass_cnt++;
        total_cnt++; if (ifc.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", ifc.rsp_valid); else pass_cnt++;
        total_cnt++; if ({ifc.add_a, ifc.add_b, ifc.rsp_sum, ifc.rsp_id} !== '0) $display("FAIL reset_data: got %h expected 0", {ifc.add_a, ifc.add_b, ifc.rsp_sum, ifc.rsp_id}); else pass_cnt++;
        total_cnt++; if (ifc.op_count !== '0 || ifc.busy !== 1'b0) $display("FAIL reset_cnt_busy: got %0d/%b expected 0/0", ifc.op_count, ifc.busy); else pass_cnt++;
        ifc.req_valid = '0;
        rst_n = 1'b1;
        model_last = NREQ - 1;
        model_count = 0;
        tick(); tick();
        total_cnt++; if (ifc.busy !== 1'b0 || ifc.req_ready !== '0 || ifc.rsp_valid !== 1'b0) $display("FAIL idle_after_reset: got busy=%b ready=%b valid=%b expected 0", ifc.busy, ifc.req_ready, ifc.rsp_valid); else pass_cnt++;
    endtask

    task automatic test_single();
        logic [NREQ-1:0] rdy; int waits, lat; logic [IDW-1:0] id; logic [WIDTH-1:0] sum;
        opa[2] = 5'd3; opb[2] = 5'd4;
        issue(4'b0100, 1'b0, rdy, waits, lat, id, sum);
        total_cnt++; if (rdy !== 4'b0100 || waits != 0) $display("FAIL single_ready: got %b after %0d expected 0100 after 0", rdy, waits); else pass_cnt++;
        total_cnt++; if (lat != 2) $display("FAIL single_latency: got %0d expected 2", lat); else pass_cnt++;
        total_cnt++; if (id !== 2'd2 || sum !== 5'd7) $display("FAIL single_rsp: got id=%0d sum=%0d expected id=2 sum=7", id, sum); else pass_cnt++;
        total_cnt++; if (ifc.busy !== 1'b1) $display("FAIL single_busy: got %b expected 1", ifc.busy); else pass_cnt++;
        tick();
        model_last = 2; model_count++;
        total_cnt++; if (ifc.op_count !== CNTW'(model_count) || ifc.rsp_valid !== 1'b0 || ifc.busy !== 1'b0) $display("FAIL single_done: got cnt=%0d valid=%b busy=%b expected cnt=%0d valid=0 busy=0", ifc.op_count, ifc.rsp_valid, ifc.busy, model_count); else pass_cnt++;
    endtask

    task automatic test_sum_wrap();
        logic [NREQ-1:0] rdy; int waits, lat; logic [IDW-1:0] id; logic [WIDTH-1:0] sum;
        opa[0] = 5'd20; opb[0] = 5'd15;
        issue(4'b0001, 1'b0, rdy, waits, lat, id, sum);
        total_cnt++; if (id !== 2'd0 || sum !== 5'd3) $display("FAIL sum_wrap: got id=%0d sum=%0d expected id=0 sum=3", id, sum); else pass_cnt++;
        tick();
        model_last = 0; model_count++;
    endtask

    task automatic test_fairness();
        logic [NREQ-1:0] rdy; int waits, lat, g; logic [IDW-1:0] id; logic [WIDTH-1:0] sum;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin opa[i] = WIDTH'(i); opb[i] = 5'd1; end
        for (int n = 0; n < 5; n++) begin
            g = rr_pick('1, model_last);
            issue('1, 1'b1, rdy, waits, lat, id, sum);
            total_cnt++; if (id !== IDW'(g) || sum !== ref_sum(g)) $display("FAIL fair_op%0d: got id=%0d sum=%0d expected id=%0d sum=%0d", n, id, sum, g, ref_sum(g)); else pass_cnt++;
            total_cnt++; if (waits != 0) $display("FAIL fair_interval%0d: got %0d extra cycles expected 0", n, waits); else pass_cnt++;
            tick();
            model_last = g; model_count++;
        end
        ifc.req_valid = '0;
        total_cnt++; if (ifc.op_count !== CNTW'(5)) $display("FAIL fair_count: got %0d expected 5", ifc.op_count); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [NREQ-1:0] rdy, v; int waits, lat, g; logic [IDW-1:0] id; logic [WIDTH-1:0] sum;
        for (int n = 0; n < 20; n++) begin
            v = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin opa[i] = WIDTH'($urandom); opb[i] = WIDTH'($urandom); end
            g = rr_pick(v, model_last);
            issue(v, 1'b0, rdy, waits, lat, id, sum);
            total_cnt++; if (rdy !== onehot(g) || id !== IDW'(g) || sum !== ref_sum(g)) $display("FAIL rand_op%0d: got rdy=%b id=%0d sum=%0d expected rdy=%b id=%0d sum=%0d", n, rdy, id, sum, onehot(g), g, ref_sum(g)); else pass_cnt++;
            tick();
            model_last = g; model_count++;
        end
        ifc.req_valid = '0;
        total_cnt++; if (ifc.op_count !== CNTW'(model_count)) $display("FAIL rand_count: got %0d expected %0d", ifc.op_count, CNTW'(model_count)); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [NREQ-1:0] rdy; int waits, lat, g; logic [IDW-1:0] id; logic [WIDTH-1:0] sum;
        bit stable;
        ifc.rsp_ready = 1'b0;
        opa[3] = 5'd9; opb[3] = 5'd30;
        issue(4'b1000, 1'b0, rdy, waits, lat, id, sum);
        total_cnt++; if (id !== 2'd3 || sum !== 5'd7 || lat != 2) $display("FAIL bp_rsp: got id=%0d sum=%0d lat=%0d expected 3/7/2", id, sum, lat); else pass_cnt++;
        model_last = 3;
        opa[1] = 5'd5; opb[1] = 5'd6;
        set_ops();
        ifc.req_valid = 4'b0010;
        stable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (ifc.rsp_valid !== 1'b1 || ifc.rsp_id !== 2'd3 || ifc.rsp_sum !== 5'd7 || ifc.req_ready !== '0 || ifc.add_a !== 5'd9) stable = 1'b0;
        end
        total_cnt++; if (!stable) $display("FAIL bp_hold: got valid=%b id=%0d sum=%0d ready=%b expected 1/3/7/0000", ifc.rsp_valid, ifc.rsp_id, ifc.rsp_sum, ifc.req_ready); else pass_cnt++;
        ifc.rsp_ready = 1'b1;
        tick();
        model_count++;
        g = rr_pick(4'b0010, model_last);
        total_cnt++; if (ifc.req_ready !== onehot(g)) $display("FAIL bp_next_grant: got %b expected %b", ifc.req_ready, onehot(g)); else pass_cnt++;
        issue(4'b0010, 1'b0, rdy, waits, lat, id, sum);
        total_cnt++; if (id !== IDW'(g) || sum !== ref_sum(g)) $display("FAIL bp_next_rsp: got id=%0d sum=%0d expected %0d/%0d", id, sum, g, ref_sum(g)); else pass_cnt++;
        tick();
        model_last = g; model_count++;
    endtask

    task automatic test_async_reset();
        logic [NREQ-1:0] rdy; int waits, lat; logic [IDW-1:0] id; logic [WIDTH-1:0] sum;
        ifc.rsp_ready = 1'b0;
        opa[2] = 5'd1; opb[2] = 5'd2;
        issue(4'b0100, 1'b0, rdy, waits, lat, id, sum);
        total_cnt++; if (ifc.rsp_valid !== 1'b1) $display("FAIL ar_in_resp: got %b expected 1", ifc.rsp_valid); else pass_cnt++;
        ifc.req_valid = '1;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if (ifc.rsp_valid !== 1'b0 || ifc.busy !== 1'b0 || ifc.req_ready !== '0) $display("FAIL ar_immediate: got valid=%b busy=%b ready=%b expected 0", ifc.rsp_valid, ifc.busy, ifc.req_ready); else pass_cnt++;
        total_cnt++; if (ifc.op_count !== '0) $display("FAIL ar_count: got %0d expected 0", ifc.op_count); else pass_cnt++;
        @(posedge clk); #1 rst_n = 1'b1;
        ifc.rsp_ready = 1'b1;
        #1;
        model_last = NREQ - 1; model_count = 0;
        total_cnt++; if (ifc.req_ready !== onehot(rr_pick('1, model_last))) $display("FAIL ar_first_grant: got %b expected %b", ifc.req_ready, onehot(rr_pick('1, model_last))); else pass_cnt++;
        ifc.req_valid = '0;
    endtask

    task automatic test_count_wrap();
        logic [NREQ-1:0] rdy; int waits, lat; logic [IDW-1:0] id; logic [WIDTH-1:0] sum;
        do_reset();
        for (int n = 0; n < (1 << CNTW) + 1; n++) begin
            opa[0] = WIDTH'($urandom); opb[0] = WIDTH'($urandom);
            issue(4'b0001, 1'b0, rdy, waits, lat, id, sum);
            tick();
            model_count++;
            if (n >= (1 << CNTW) - 2) begin
                total_cnt++; if (ifc.op_count !== CNTW'(model_count % (1 << CNTW))) $display("FAIL cnt_wrap%0d: got %0d expected %0d", n, ifc.op_count, model_count % (1 << CNTW)); else pass_cnt++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_sum_wrap();
        test_fairness();
        test_random();
        test_backpressure();
        test_async_reset();
        test_count_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
